mem_req_responder: RTL and testbench

Memory-side responder for the pipelined CPU's MEM-stage data port. It accepts one load or store request at a time and completes it after a fixed, parameterised latency from an internal word array. It returns load data with a one-cycle acknowledge. While a request is in flight it drives a stall that the hazard logic uses to freeze the pipeline. This replaces the single-cycle data memory with a multi-cycle one, so the CPU's variable-latency memory path can be exercised.

---
 rtl/mem_req_responder.sv | 152 +++++++++++++++
 tb/tb_mem_req_responder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_responder.sv
// Multi-cycle data-memory responder for the MEM stage: one load/store in flight,
// completed after LATENCY cycles with a one-cycle ack, stalling the pipeline meanwhile.
module mem_req_responder #(
    parameter int unsigned DEPTH   = 32,
    parameter int unsigned LATENCY = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic        ack_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int unsigned IDX_W    = $clog2(DEPTH);
    localparam logic [3:0]  CNT_INIT = (LATENCY >= 32'd2) ? 4'(LATENCY - 32'd2) : 4'd0;
    localparam bit          LAT_ONE  = (LATENCY == 32'd1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t             r_state;
    logic [3:0]         r_cnt;
    logic               r_we;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;
    logic               r_ack;
    logic               r_err;
    logic [31:0]        r_rdata;
    logic [31:0]        r_mem [DEPTH];

    logic               w_op_we;
    logic [31:0]        w_op_addr;
    logic [31:0]        w_op_wdata;
    logic               w_done_entry;
    logic               w_fault;
    logic [IDX_W-1:0]   w_idx;
    logic               w_mem_we;
    logic [31:0]        w_rd_word;

    // Misaligned word access or a word index beyond the array both fault.
    function automatic logic f_is_fault(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= DEPTH);
    endfunction

    // Select the operation fields: live inputs when completing straight out of IDLE, latched copy otherwise.
    always_comb begin
        w_op_we    = r_we;
        w_op_addr  = r_addr;
        w_op_wdata = r_wdata;
        if (r_state == ST_IDLE) begin
            w_op_we    = we_i;
            w_op_addr  = addr_i;
            w_op_wdata = wdata_i;
        end else begin
            w_op_we    = r_we;
            w_op_addr  = r_addr;
            w_op_wdata = r_wdata;
        end
    end

    assign w_done_entry = ((r_state == ST_IDLE) && req_i && LAT_ONE) ||
                          ((r_state == ST_WAIT) && (r_cnt == 4'd0));
    assign w_fault      = f_is_fault(w_op_addr);
    assign w_idx        = w_op_addr[IDX_W+1:2];
    assign w_mem_we     = w_done_entry && !w_fault && w_op_we;
    assign w_rd_word    = r_mem[w_idx];

    // Word array: not reset; a store commits only on the edge that enters DONE.
    always_ff @(posedge clk_i) begin
        if (w_mem_we && rst_i) begin
            r_mem[w_idx] <= w_op_wdata;
        end
    end

    // Request FSM with registered ack/err/rdata.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_i) begin
                        r_we    <= we_i;
                        r_addr  <= addr_i;
                        r_wdata <= wdata_i;
                        if (LAT_ONE) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_cnt   <= CNT_INIT;
                            r_state <= ST_WAIT;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt   <= r_cnt - 4'd1;
                        r_state <= ST_WAIT;
                    end
                end
                ST_DONE: begin
                    r_ack   <= 1'b0;
                    r_err   <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_ack   <= 1'b0;
                    r_err   <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase

            // Completion results land on the same edge that enters DONE.
            if (w_done_entry) begin
                r_ack <= 1'b1;
                if (w_fault) begin
                    r_err   <= 1'b1;
                    r_rdata <= 32'd0;
                end else begin
                    r_err <= 1'b0;
                    if (!w_op_we) begin
                        r_rdata <= w_rd_word;
                    end
                end
            end
        end
    end

    assign stall_o = ((r_state == ST_IDLE) && req_i) || (r_state == ST_WAIT);
    assign ack_o   = r_ack;
    assign err_o   = r_err;
    assign rdata_o = r_rdata;

endmodule

// File: tb/tb_mem_req_responder.sv
// Scoreboard bench for mem_req_responder: a LATENCY=3 instance for the main checks
// and a LATENCY=1 instance for the single-cycle-latency timing.
module tb_mem_req_responder;

    localparam int DEPTH = 32;

    typedef struct {
        int          cyc;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    logic        req, we, stall, ack, err;
    logic [31:0] addr, wdata, rdata;
    logic        req1, we1, stall1, ack1, err1;
    logic [31:0] addr1, wdata1, rdata1;

    exp_t        q3[$];
    exp_t        q1[$];
    logic [31:0] mdl [DEPTH];
    logic [31:0] last_rd;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_req_responder #(.DEPTH(DEPTH), .LATENCY(3)) u_dut3 (
        .clk_i(clk), .rst_i(rst_n), .req_i(req), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .stall_o(stall), .ack_o(ack), .rdata_o(rdata), .err_o(err)
    );

    mem_req_responder #(.DEPTH(DEPTH), .LATENCY(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst_n), .req_i(req1), .we_i(we1), .addr_i(addr1),
        .wdata_i(wdata1), .stall_o(stall1), .ack_o(ack1), .rdata_o(rdata1), .err_o(err1)
    );

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Scoreboard pops: every ack must match the oldest pending expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && ack === 1'b1) begin
            if (q3.size() == 0) begin
                chk_val("ack3_unexpected", 32'd1, 32'd0);
            end else begin
                e = q3.pop_front();
                chk_val("ack3_cycle", cyc, e.cyc);
                chk_val("err3", {31'd0, err}, {31'd0, e.err});
                chk_val("rdata3", rdata, e.rdata);
            end
        end
        if (rst_n === 1'b1 && ack1 === 1'b1) begin
            if (q1.size() == 0) begin
                chk_val("ack1_unexpected", 32'd1, 32'd0);
            end else begin
                e = q1.pop_front();
                chk_val("ack1_cycle", cyc, e.cyc);
                chk_val("err1", {31'd0, err1}, {31'd0, e.err});
                chk_val("rdata1", rdata1, e.rdata);
            end
        end
    end

    // One request on the LATENCY=3 instance; optionally scramble the inputs after acceptance.
    task automatic req3(input logic w, input logic [31:0] a, input logic [31:0] d, input bit mangle);
        exp_t e;
        logic f;
        bit   got;
        @(posedge clk);
        #1;
        f = (a[1:0] != 2'b00) || (a[31:2] >= DEPTH);
        if (f) last_rd = 32'd0;
        else if (!w) last_rd = mdl[a[6:2]];
        else mdl[a[6:2]] = d;
        e.cyc   = cyc + 3;
        e.err   = f;
        e.rdata = last_rd;
        q3.push_back(e);
        req = 1'b1; we = w; addr = a; wdata = d;
        if (mangle) begin
            @(posedge clk);
            #1;
            addr = 32'h20; we = 1'b0; wdata = ~d;
        end
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ack === 1'b1) begin
                got = 1'b1;
                break;
            end
            chk_val("stall3_busy", {31'd0, stall}, 32'd1);
        end
        if (!got) chk_val("ack3_timeout", 32'd0, 32'd1);
        chk_val("stall3_done", {31'd0, stall}, 32'd0);
        req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        exp_t e;
        rst_n = 1'b0;
        req = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0;
        req1 = 1'b0; we1 = 1'b0; addr1 = 32'd0; wdata1 = 32'd0;
        last_rd = 32'd0;
        repeat (3) @(negedge clk);
        chk_val("rst_ack", {31'd0, ack}, 32'd0);
        chk_val("rst_err", {31'd0, err}, 32'd0);
        chk_val("rst_rdata", rdata, 32'd0);
        chk_val("rst_stall", {31'd0, stall}, 32'd0);
        chk_val("rst_rdata1", rdata1, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < DEPTH; i++)
            req3(1'b1, 32'(i * 4), 32'hA5A5_0000 ^ (32'(i) * 32'h0101_0101), 1'b0);

        req3(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0);
        req3(1'b0, 32'h10, 32'd0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk_val("rdata_hold", rdata, 32'hDEAD_BEEF);
        end

        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_val("async_rdata", rdata, 32'd0);
        chk_val("async_ack", {31'd0, ack}, 32'd0);
        chk_val("async_stall", {31'd0, stall}, 32'd0);
        #1 rst_n = 1'b1;
        last_rd = 32'd0;

        req3(1'b0, 32'h10, 32'd0, 1'b0);
        req3(1'b0, 32'h13, 32'd0, 1'b0);
        req3(1'b1, 32'h80, 32'h1234_5678, 1'b0);

        @(posedge clk);
        #1;
        req = 1'b1; we = 1'b1; addr = 32'h04; wdata = 32'hAAAA_5555;
        @(posedge clk);
        #1;
        chk_val("midrst_stall_wait", {31'd0, stall}, 32'd1);
        rst_n = 1'b0;
        req = 1'b0;
        #1;
        chk_val("midrst_stall", {31'd0, stall}, 32'd0);
        chk_val("midrst_ack", {31'd0, ack}, 32'd0);
        #2 rst_n = 1'b1;
        last_rd = 32'd0;
        repeat (6) @(negedge clk);
        req3(1'b0, 32'h04, 32'd0, 1'b0);

        req3(1'b1, 32'h08, 32'h1357_2468, 1'b1);
        req3(1'b0, 32'h08, 32'd0, 1'b0);
        req3(1'b0, 32'h20, 32'd0, 1'b0);

        for (int i = 0; i < DEPTH; i++)
            req3(1'b0, 32'(i * 4), 32'd0, 1'b0);

        @(posedge clk);
        #1;
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h0C; wdata1 = 32'hCAFE_F00D;
        t = cyc;
        for (int k = 1; k <= 5; k += 2) begin
            e.cyc = t + k; e.err = 1'b0; e.rdata = 32'd0;
            q1.push_back(e);
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk_val("stall1_pattern", {31'd0, stall1}, (k % 2 == 0) ? 32'd1 : 32'd0);
        end
        req1 = 1'b0;

        @(posedge clk);
        #1;
        req1 = 1'b1; we1 = 1'b0;
        e.cyc = cyc + 1; e.err = 1'b0; e.rdata = 32'hCAFE_F00D;
        q1.push_back(e);
        @(negedge clk);
        chk_val("stall1_req", {31'd0, stall1}, 32'd1);
        @(negedge clk);
        chk_val("stall1_done", {31'd0, stall1}, 32'd0);
        chk_val("ack1_seen", {31'd0, ack1}, 32'd1);
        req1 = 1'b0;

        repeat (4) @(negedge clk);
        chk_val("q3_drain", 32'(q3.size()), 32'd0);
        chk_val("q1_drain", 32'(q1.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
